// File: rtl/mpu_bus_master_pkg.sv
// Shared definitions for the ChronoCube MPU bus master.
//  - mpu_state_e : bus-cycle FSM state encoding (IDLE..RESP), also used by monitors/benches
//  - mpu_cnt_width / mpu_max3 : sizing helpers for the phase down-counter
package mpu_bus_master_pkg;

    localparam int unsigned MpuAddrWidth = 16;
    localparam int unsigned MpuDataWidth = 16;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSetup  = 3'd1,
        StStrobe = 3'd2,
        StHold   = 3'd3,
        StResp   = 3'd4
    } mpu_state_e;

    // Counter width able to hold (max_cycles - 1); never narrower than 1 bit.
    function automatic int unsigned mpu_cnt_width(input int unsigned max_cycles);
        return (max_cycles > 1) ? $clog2(max_cycles) : 1;
    endfunction

    function automatic int unsigned mpu_max3(input int unsigned a, input int unsigned b,
                                             input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/mpu_phase_counter.sv
// Loadable down-counter timing the SETUP/STROBE/HOLD phases.
// Ports:
//  clk_i      : clock
//  reset_i    : synchronous reset, active high (count clears to 0)
//  load_i     : load load_val_i on the next edge (priority over counting)
//  load_val_i : phase length minus one
//  tc_o       : terminal count, high while the count is 0 (last cycle of the phase)
module mpu_phase_counter #(
    parameter int unsigned Width = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             tc_o
);

    logic [Width-1:0] count_q, count_d;

    assign tc_o = (count_q == '0);

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (!tc_o) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mpu_bus_master.sv
// ChronoCube MPU bus initiator: turns valid/ready requests into setup/strobe/hold bus cycles
// and returns read data (or a zero write acknowledge) on a valid/ready response port.
// Ports:
//  clk, reset (sync, active high)
//  req_valid/req_ready/req_write/req_addr/req_data/req_be : request port (be active high)
//  rsp_valid/rsp_ready/rsp_data                             : response port
//  busy                                                     : FSM not idle
//  _mpu_en/_mpu_rd/_mpu_wr/_mpu_be (active low), mpu_addr_out, mpu_data_out, mpu_data_in : bus
// Build option: MPU_MASTER_POSTED_WRITE_EN - writes return to IDLE without a response.
module mpu_bus_master
    import mpu_bus_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = MpuAddrWidth,
    parameter int unsigned DATA_WIDTH    = MpuDataWidth,
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic [1:0]            req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  busy,
    output logic                  _mpu_en,
    output logic                  _mpu_rd,
    output logic                  _mpu_wr,
    output logic [1:0]            _mpu_be,
    output logic [ADDR_WIDTH-1:0] mpu_addr_out,
    output logic [DATA_WIDTH-1:0] mpu_data_out,
    input  logic [DATA_WIDTH-1:0] mpu_data_in
);

    localparam int unsigned MaxPhase = mpu_max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
    localparam int unsigned CntW     = mpu_cnt_width(MaxPhase);

    // Counter load values are phase length minus one; zero-length phases are never loaded.
    localparam logic [CntW-1:0] SetupLd  = CntW'((SETUP_CYCLES > 0) ? SETUP_CYCLES - 1 : 0);
    localparam logic [CntW-1:0] StrobeLd = CntW'(STROBE_CYCLES - 1);
    localparam logic [CntW-1:0] HoldLd   = CntW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

`ifdef MPU_MASTER_POSTED_WRITE_EN
    localparam bit PostedWrite = 1'b1;
`else
    localparam bit PostedWrite = 1'b0;
`endif

    mpu_state_e state_q, state_d, bus_end_state;

    logic                  cnt_load, cnt_tc;
    logic [CntW-1:0]       cnt_load_val;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]            be_n_q, be_n_d;
    logic                  en_n_q, en_n_d;
    logic                  rd_n_q, rd_n_d;
    logic                  wr_n_q, wr_n_d;

    mpu_phase_counter #(
        .Width (CntW)
    ) u_phase_counter (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .tc_o       (cnt_tc)
    );

    // Where the bus cycle ends: posted writes skip the response phase.
    assign bus_end_state = (PostedWrite && write_q) ? StIdle : StResp;

    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = StrobeLd;
        write_d      = write_q;
        addr_d       = addr_q;
        dout_d       = dout_q;
        be_n_d       = be_n_q;
        rsp_data_d   = rsp_data_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    write_d    = req_write;
                    addr_d     = req_addr;
                    dout_d     = req_write ? req_data : '0;
                    be_n_d     = ~req_be;
                    rsp_data_d = '0;
                    cnt_load   = 1'b1;
                    if (SETUP_CYCLES > 0) begin
                        state_d      = StSetup;
                        cnt_load_val = SetupLd;
                    end else begin
                        state_d      = StStrobe;
                        cnt_load_val = StrobeLd;
                    end
                end
            end
            StSetup: begin
                if (cnt_tc) begin
                    state_d      = StStrobe;
                    cnt_load     = 1'b1;
                    cnt_load_val = StrobeLd;
                end
            end
            StStrobe: begin
                if (cnt_tc) begin
                    // Sync RAM data is valid by the edge closing the last strobe cycle.
                    if (!write_q) begin
                        rsp_data_d = mpu_data_in;
                    end
                    if (HOLD_CYCLES > 0) begin
                        state_d      = StHold;
                        cnt_load     = 1'b1;
                        cnt_load_val = HoldLd;
                    end else begin
                        state_d = bus_end_state;
                    end
                end
            end
            StHold: begin
                if (cnt_tc) begin
                    state_d = bus_end_state;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Strobes are registered from the next state so they change cleanly on the edge.
        en_n_d = !((state_d == StSetup) || (state_d == StStrobe) || (state_d == StHold));
        rd_n_d = !((state_d == StStrobe) && !write_d);
        wr_n_d = !((state_d == StStrobe) && write_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            write_q    <= 1'b0;
            addr_q     <= '0;
            dout_q     <= '0;
            be_n_q     <= 2'b11;
            rsp_data_q <= '0;
            en_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
            be_n_q     <= be_n_d;
            rsp_data_q <= rsp_data_d;
            en_n_q     <= en_n_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
        end
    end

    assign req_ready    = (state_q == StIdle) && !reset;
    assign rsp_valid    = (state_q == StResp) && !reset;
    assign busy         = (state_q != StIdle) && !reset;
    assign rsp_data     = rsp_data_q;
    assign _mpu_en      = en_n_q;
    assign _mpu_rd      = rd_n_q;
    assign _mpu_wr      = wr_n_q;
    assign _mpu_be      = be_n_q;
    assign mpu_addr_out = addr_q;
    assign mpu_data_out = dout_q;

endmodule

// File: tb/tb_mpu_bus_master.sv
// Directed bench for mpu_bus_master: default-timing instance plus a SETUP=0/HOLD=0/STROBE=3
// instance, each with a small synchronous-RAM style responder.
module tb_mpu_bus_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, f_req_valid;
    logic        req_write;
    logic [15:0] req_addr, req_data;
    logic [1:0]  req_be;
    logic        rsp_ready;

    logic        req_ready, rsp_valid, busy, mpu_en_n, mpu_rd_n, mpu_wr_n;
    logic [15:0] rsp_data, mpu_addr, mpu_dout, mpu_din;
    logic [1:0]  mpu_be_n;

    logic        f_req_ready, f_rsp_valid, f_busy, f_en_n, f_rd_n, f_wr_n;
    logic [15:0] f_rsp_data, f_addr, f_dout, f_din;
    logic [1:0]  f_be_n;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mpu_bus_master #(
        .ADDR_WIDTH    (16),
        .DATA_WIDTH    (16),
        .SETUP_CYCLES  (1),
        .STROBE_CYCLES (2),
        .HOLD_CYCLES   (1)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_be       (req_be),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .busy         (busy),
        ._mpu_en      (mpu_en_n),
        ._mpu_rd      (mpu_rd_n),
        ._mpu_wr      (mpu_wr_n),
        ._mpu_be      (mpu_be_n),
        .mpu_addr_out (mpu_addr),
        .mpu_data_out (mpu_dout),
        .mpu_data_in  (mpu_din)
    );

    mpu_bus_master #(
        .ADDR_WIDTH    (16),
        .DATA_WIDTH    (16),
        .SETUP_CYCLES  (0),
        .STROBE_CYCLES (3),
        .HOLD_CYCLES   (0)
    ) u_dut_fast (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (f_req_valid),
        .req_ready    (f_req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_be       (req_be),
        .rsp_valid    (f_rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (f_rsp_data),
        .busy         (f_busy),
        ._mpu_en      (f_en_n),
        ._mpu_rd      (f_rd_n),
        ._mpu_wr      (f_wr_n),
        ._mpu_be      (f_be_n),
        .mpu_addr_out (f_addr),
        .mpu_data_out (f_dout),
        .mpu_data_in  (f_din)
    );

    // Responder: read data appears one cycle after _mpu_rd falls; writes honour byte enables.
    logic [15:0] mem [0:15];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'h0000;
            mem[0] <= 16'h1234;
            mem[1] <= 16'h5A3C;
            mem[2] <= 16'hA5A5;
        end else if (!mpu_wr_n) begin
            if (!mpu_be_n[0]) mem[mpu_addr[3:0]][7:0]  <= mpu_dout[7:0];
            if (!mpu_be_n[1]) mem[mpu_addr[3:0]][15:8] <= mpu_dout[15:8];
        end
        mpu_din <= !mpu_rd_n ? mem[mpu_addr[3:0]] : 16'h0000;
        f_din   <= !f_rd_n ? 16'hC0DE : 16'h0000;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Per-cycle capture; bit/index c-1 (or c) holds the value seen during cycle c after accept.
    logic [31:0] tr_en, tr_rd, tr_wr, tr_rv, tr_rdy, tr_busy;
    logic [15:0] cap_addr  [1:32];
    logic [15:0] cap_dout  [1:32];
    logic [15:0] cap_rdata [1:32];
    logic [1:0]  cap_be    [1:32];

    task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [15:0] data,
                           input logic [1:0] be, input int ncyc, input int rst_at,
                           input bit hold_valid);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_data  = data;
        req_be    = be;
        tr_en = '0; tr_rd = '0; tr_wr = '0; tr_rv = '0; tr_rdy = '0; tr_busy = '0;
        check_eq("accept_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (c == 1 && !hold_valid) req_valid = 1'b0;
            tr_en[c-1]   = mpu_en_n;
            tr_rd[c-1]   = mpu_rd_n;
            tr_wr[c-1]   = mpu_wr_n;
            tr_rv[c-1]   = rsp_valid;
            tr_rdy[c-1]  = req_ready;
            tr_busy[c-1] = busy;
            cap_addr[c]  = mpu_addr;
            cap_dout[c]  = mpu_dout;
            cap_rdata[c] = rsp_data;
            cap_be[c]    = mpu_be_n;
            if (rst_at != 0 && c == rst_at) reset = 1'b1;
            else if (rst_at != 0 && c == rst_at + 1) reset = 1'b0;
        end
        req_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; f_req_valid = 1'b0; req_write = 1'b0;
        req_addr = 16'h0; req_data = 16'h0; req_be = 2'b00; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        // Reset state (reset still high).
        check_eq("rst_strobes", {28'b0, mpu_en_n, mpu_rd_n, mpu_wr_n, 1'b0}, 32'hE);
        check_eq("rst_be", {30'b0, mpu_be_n}, 32'h3);
        check_eq("rst_addr_data", {mpu_addr, mpu_dout}, 32'h0);
        check_eq("rst_rsp", {15'b0, rsp_valid, rsp_data}, 32'h0);
        check_eq("rst_busy_rdy", {30'b0, busy, req_ready}, 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 1: read 0x0000 -> 0x1234, strobe c2-c3, response c5, ready again c6.
        run_txn(1'b0, 16'h0000, 16'hFFFF, 2'b11, 6, 0, 1'b0);
        check_eq("t1_rd_trace", tr_rd, 32'h39);
        check_eq("t1_wr_trace", tr_wr, 32'h3F);
        check_eq("t1_en_trace", tr_en, 32'h30);
        check_eq("t1_rv_trace", tr_rv, 32'h10);
        check_eq("t1_busy_trace", tr_busy, 32'h1F);
        check_eq("t1_rdy_trace", tr_rdy, 32'h20);
        check_eq("t1_rsp_data", {16'b0, cap_rdata[5]}, 32'h1234);
        check_eq("t1_read_dout_zero", {16'b0, cap_dout[2]}, 32'h0);

        // 2: write 0x4002 <= 0xBEEF, low byte only.
        run_txn(1'b1, 16'h4002, 16'hBEEF, 2'b01, 6, 0, 1'b0);
        check_eq("t2_wr_trace", tr_wr, 32'h39);
        check_eq("t2_rd_trace", tr_rd, 32'h3F);
        check_eq("t2_en_trace", tr_en, 32'h30);
        check_eq("t2_be", {30'b0, cap_be[2]}, 32'h2);
        check_eq("t2_addr", {16'b0, cap_addr[2]}, 32'h4002);
        for (int c = 1; c <= 4; c++) check_eq("t2_dout_stable", {16'b0, cap_dout[c]}, 32'hBEEF);
`ifdef MPU_MASTER_POSTED_WRITE_EN
        check_eq("t2_rv_trace", tr_rv, 32'h00);
        check_eq("t2_rdy_trace", tr_rdy, 32'h30);
`else
        check_eq("t2_rv_trace", tr_rv, 32'h10);
        check_eq("t2_rdy_trace", tr_rdy, 32'h20);
        check_eq("t2_rsp_data", {16'b0, cap_rdata[5]}, 32'h0);
`endif

        // Read back the partially written word: only the low byte changed.
        run_txn(1'b0, 16'h0002, 16'h0000, 2'b11, 6, 0, 1'b0);
        check_eq("t2b_readback", {16'b0, cap_rdata[5]}, 32'hA5EF);

        // 3: response backpressure for 11 cycles.
        rsp_ready = 1'b0;
        run_txn(1'b0, 16'h0001, 16'h0000, 2'b11, 15, 0, 1'b0);
        check_eq("t3_rv_held", tr_rv, 32'h7FF0);
        check_eq("t3_rdy_low", tr_rdy, 32'h0);
        check_eq("t3_rd_trace", tr_rd, 32'h7FF9);
        check_eq("t3_en_trace", tr_en, 32'h7FF0);
        check_eq("t3_wr_idle", tr_wr, 32'h7FFF);
        check_eq("t3_data_c5", {16'b0, cap_rdata[5]}, 32'h5A3C);
        check_eq("t3_data_c15", {16'b0, cap_rdata[15]}, 32'h5A3C);
        rsp_ready = 1'b1;
        @(negedge clk);
        check_eq("t3_release", {30'b0, rsp_valid, req_ready}, 32'h1);

        // 4: reset during the first strobe cycle of a write.
        run_txn(1'b1, 16'h0005, 16'h7777, 2'b11, 10, 2, 1'b0);
        check_eq("t4_wr_trace", tr_wr, 32'h3FD);
        check_eq("t4_en_trace", tr_en, 32'h3FC);
        check_eq("t4_rv_none", tr_rv, 32'h0);
        check_eq("t4_busy_trace", tr_busy, 32'h3);
        check_eq("t4_rdy_trace", tr_rdy, 32'h3F8);
        check_eq("t4_addr_cleared", {16'b0, cap_addr[3]}, 32'h0);
        run_txn(1'b0, 16'h0000, 16'h0000, 2'b11, 6, 0, 1'b0);
        check_eq("t4_after_rv", tr_rv, 32'h10);
        check_eq("t4_after_data", {16'b0, cap_rdata[5]}, 32'h1234);

`ifdef MPU_MASTER_POSTED_WRITE_EN
        // 5: four back-to-back posted writes, one every 5 cycles, then a read.
        run_txn(1'b1, 16'h0008, 16'h1111, 2'b11, 20, 0, 1'b1);
        check_eq("t5_wr_trace", tr_wr, 32'hCE739);
        check_eq("t5_rv_none", tr_rv, 32'h0);
        run_txn(1'b0, 16'h0008, 16'h0000, 2'b11, 6, 0, 1'b0);
        check_eq("t5_read_rv", tr_rv, 32'h10);
        check_eq("t5_read_data", {16'b0, cap_rdata[5]}, 32'h1111);
`endif

        // 6: SETUP=0, HOLD=0, STROBE=3 instance: en and rd coincide for 3 cycles.
        @(negedge clk);
        f_req_valid = 1'b1;
        req_write   = 1'b0;
        req_addr    = 16'h0003;
        tr_en = '0; tr_rd = '0; tr_rv = '0;
        check_eq("t6_accept_ready", {31'b0, f_req_ready}, 32'd1);
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) f_req_valid = 1'b0;
            tr_en[c-1]   = f_en_n;
            tr_rd[c-1]   = f_rd_n;
            tr_rv[c-1]   = f_rsp_valid;
            cap_rdata[c] = f_rsp_data;
        end
        check_eq("t6_en_trace", tr_en, 32'h38);
        check_eq("t6_rd_trace", tr_rd, 32'h38);
        check_eq("t6_rv_trace", tr_rv, 32'h08);
        check_eq("t6_rsp_data", {16'b0, cap_rdata[4]}, 32'hC0DE);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
